// File: rtl/fp_mul_seq_param.sv
`default_nettype none
// ============================================================================
//  Module   : fp_mul_seq_param
//  Brief    : Sequential IEEE-style floating-point multiplier with a two-word
//             four-phase input handshake, shift-add significand multiply,
//             round-to-nearest-even and flushed subnormals.
//  Revision : 1.0  initial release
// ============================================================================
module fp_mul_seq_param #(
    parameter int EW = 8,
    parameter int MW = 23
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           inReady,
    input  logic [EW+MW:0] inBus,
    output logic           inAccepted,
    input  logic           resultAccepted,
    output logic [EW+MW:0] outBus,
    output logic           resultReady,
    output logic           ovf,
    output logic           unf,
    output logic           inv
);

    localparam int W  = 1 + EW + MW;
    localparam int PW = 2 * (MW + 1);
    localparam int CW = $clog2(MW + 2);
    localparam logic [EW+1:0] BIAS     = (EW+2)'((1 << (EW - 1)) - 1);
    localparam logic [EW+1:0] EMAX     = (EW+2)'((1 << EW) - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MW + 1);

    typedef enum logic [2:0] {
        IDLE_X = 3'd0,
        ACK_X  = 3'd1,
        IDLE_Y = 3'd2,
        ACK_Y  = 3'd3,
        MUL    = 3'd4,
        NORM   = 3'd5,
        RDY    = 3'd6,
        DONE   = 3'd7
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    xreg_q, xreg_d;
    logic [W-1:0]    yreg_q, yreg_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic [MW:0]     mpl_q,  mpl_d;
    logic [CW-1:0]   cnt_q,  cnt_d;
    logic [W-1:0]    out_q,  out_d;
    logic            ovf_q,  ovf_d;
    logic            unf_q,  unf_d;
    logic            inv_q,  inv_d;

    // ---------------- operand field decode ----------------
    logic            w_xs, w_ys, w_sign;
    logic [EW-1:0]   w_xe, w_ye;
    logic [MW-1:0]   w_xf, w_yf;
    logic            w_xzero, w_yzero, w_xinf, w_yinf, w_xnan, w_ynan, w_inv;

    assign w_xs    = xreg_q[W-1];
    assign w_ys    = yreg_q[W-1];
    assign w_xe    = xreg_q[W-2:MW];
    assign w_ye    = yreg_q[W-2:MW];
    assign w_xf    = xreg_q[MW-1:0];
    assign w_yf    = yreg_q[MW-1:0];
    assign w_sign  = w_xs ^ w_ys;
    // An exponent of zero means zero: subnormal fractions are ignored.
    assign w_xzero = (w_xe == '0);
    assign w_yzero = (w_ye == '0);
    assign w_xinf  = (&w_xe) && (w_xf == '0);
    assign w_yinf  = (&w_ye) && (w_yf == '0);
    assign w_xnan  = (&w_xe) && (w_xf != '0);
    assign w_ynan  = (&w_ye) && (w_yf != '0);
    assign w_inv   = w_xnan | w_ynan | (w_xinf & w_yzero) | (w_yinf & w_xzero);

    // ---------------- shift-add step ----------------
    // Right-shifting accumulator: add the multiplicand into the upper half
    // when the current multiplier bit is set, then shift the whole product.
    logic [MW+1:0]   w_acc;
    logic [PW-1:0]   w_prod_nx;

    assign w_acc     = {1'b0, prod_q[PW-1:MW+1]} + (mpl_q[0] ? {2'b01, w_xf} : '0);
    assign w_prod_nx = {w_acc, prod_q[MW:1]};

    // ---------------- normalize / round ----------------
    logic            w_norm, w_guard, w_sticky, w_lsb, w_rup, w_carry;
    logic [PW-2:0]   w_pn;
    logic [MW:0]     w_fr;
    logic [EW+1:0]   w_e;
    logic            w_ovf_c, w_unf_c;

    assign w_norm   = prod_q[PW-1];
    assign w_pn     = w_norm ? prod_q[PW-2:0] : {prod_q[PW-3:0], 1'b0};
    assign w_lsb    = w_pn[MW+1];
    assign w_guard  = w_pn[MW];
    assign w_sticky = |w_pn[MW-1:0];
    assign w_rup    = w_guard & (w_sticky | w_lsb);
    // A rounding carry leaves the fraction all-zero, which is exactly the
    // renormalized value 1.000..; only the exponent needs the extra one.
    assign w_fr     = {1'b0, w_pn[PW-2:MW+1]} + (MW+1)'(w_rup);
    assign w_carry  = w_fr[MW];
    // Two guard bits keep the sum signed and untruncated for the range test.
    assign w_e      = {2'b00, w_xe} + {2'b00, w_ye} - BIAS
                    + (EW+2)'(w_norm) + (EW+2)'(w_carry);
    assign w_ovf_c  = !w_e[EW+1] && (w_e >= EMAX);
    assign w_unf_c  = w_e[EW+1] || (w_e == '0);

    logic [W-1:0]    w_res;
    logic            w_res_ovf, w_res_unf, w_res_inv;

    // Select the final word by special-case priority.
    always_comb begin
        w_res     = '0;
        w_res_ovf = 1'b0;
        w_res_unf = 1'b0;
        w_res_inv = 1'b0;
        if (w_inv) begin
            w_res     = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
            w_res_inv = 1'b1;
        end else if (w_xinf || w_yinf) begin
            w_res = {w_sign, {EW{1'b1}}, {MW{1'b0}}};
        end else if (w_xzero || w_yzero) begin
            w_res = {w_sign, {(W-1){1'b0}}};
        end else if (w_ovf_c) begin
            w_res     = {w_sign, {EW{1'b1}}, {MW{1'b0}}};
            w_res_ovf = 1'b1;
        end else if (w_unf_c) begin
            w_res     = {w_sign, {(W-1){1'b0}}};
            w_res_unf = 1'b1;
        end else begin
            w_res = {w_sign, w_e[EW-1:0], w_fr[MW-1:0]};
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_d     = state_q;
        xreg_d      = xreg_q;
        yreg_d      = yreg_q;
        prod_d      = prod_q;
        mpl_d       = mpl_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        inv_d       = inv_q;
        inAccepted  = (state_q == ACK_X) || (state_q == ACK_Y);
        resultReady = (state_q == RDY);
        case (state_q)
            IDLE_X: begin
                if (inReady) begin
                    xreg_d  = inBus;
                    state_d = ACK_X;
                end
            end
            ACK_X: begin
                if (!inReady) state_d = IDLE_Y;
            end
            IDLE_Y: begin
                if (inReady) begin
                    yreg_d  = inBus;
                    state_d = ACK_Y;
                end
            end
            ACK_Y: begin
                if (!inReady) begin
                    prod_d  = '0;
                    cnt_d   = '0;
                    mpl_d   = {1'b1, w_yf};
                    state_d = MUL;
                end
            end
            MUL: begin
                // MW+1 add/shift cycles, then one terminal cycle when the
                // counter reads MW+1, so latency never depends on data.
                if (cnt_q == CNT_LAST) begin
                    state_d = NORM;
                end else begin
                    prod_d = w_prod_nx;
                    mpl_d  = {1'b0, mpl_q[MW:1]};
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            NORM: begin
                out_d   = w_res;
                ovf_d   = w_res_ovf;
                unf_d   = w_res_unf;
                inv_d   = w_res_inv;
                state_d = RDY;
            end
            RDY: begin
                if (resultAccepted) state_d = DONE;
            end
            DONE: begin
                if (!resultAccepted) state_d = IDLE_X;
            end
            default: state_d = IDLE_X;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE_X;
            xreg_q  <= '0;
            yreg_q  <= '0;
            prod_q  <= '0;
            mpl_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            xreg_q  <= xreg_d;
            yreg_q  <= yreg_d;
            prod_q  <= prod_d;
            mpl_q   <= mpl_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            inv_q   <= inv_d;
        end
    end

    assign outBus = out_q;
    assign ovf    = ovf_q;
    assign unf    = unf_q;
    assign inv    = inv_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_seq_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_mul_seq_param
//  Brief    : Scoreboard bench for fp_mul_seq_param (binary32 and 5/10 builds)
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_mul_seq_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_ready;
    logic [31:0] in_bus;
    logic        res_acc;
    logic        sel;

    always #5 clk = ~clk;

    logic        acc_a, rr_a, ovf_a, unf_a, inv_a;
    logic [31:0] out_a;
    logic        acc_b, rr_b, ovf_b, unf_b, inv_b;
    logic [15:0] out_b;

    fp_mul_seq_param #(.EW(8), .MW(23)) u_dut_a (
        .clk           (clk),
        .rst           (rst),
        .inReady       (in_ready & ~sel),
        .inBus         (in_bus),
        .inAccepted    (acc_a),
        .resultAccepted(res_acc & ~sel),
        .outBus        (out_a),
        .resultReady   (rr_a),
        .ovf           (ovf_a),
        .unf           (unf_a),
        .inv           (inv_a)
    );

    fp_mul_seq_param #(.EW(5), .MW(10)) u_dut_b (
        .clk           (clk),
        .rst           (rst),
        .inReady       (in_ready & sel),
        .inBus         (in_bus[15:0]),
        .inAccepted    (acc_b),
        .resultAccepted(res_acc & sel),
        .outBus        (out_b),
        .resultReady   (rr_b),
        .ovf           (ovf_b),
        .unf           (unf_b),
        .inv           (inv_b)
    );

    logic w_acc, w_rr;
    assign w_acc = sel ? acc_b : acc_a;
    assign w_rr  = sel ? rr_b  : rr_a;

    int n_vec = 0;
    int n_err = 0;

    // Expected entries: {outBus (zero-extended to 32), ovf, unf, inv}
    logic [34:0] q_a[$];
    logic [34:0] q_b[$];
    logic [34:0] exp_a, exp_b;
    logic        rr_a_prev = 1'b0;
    logic        rr_b_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor for the binary32 instance: compare on each rising resultReady.
    always @(negedge clk) begin
        if (rr_a && !rr_a_prev) begin
            if (q_a.size() == 0) begin
                check("A unexpected resultReady", 64'd1, 64'd0);
            end else begin
                exp_a = q_a.pop_front();
                check("A outBus", {32'd0, out_a}, {32'd0, exp_a[34:3]});
                check("A flags", {61'd0, ovf_a, unf_a, inv_a}, {61'd0, exp_a[2:0]});
            end
        end
        rr_a_prev <= rr_a;
    end

    // Monitor for the half-width instance.
    always @(negedge clk) begin
        if (rr_b && !rr_b_prev) begin
            if (q_b.size() == 0) begin
                check("B unexpected resultReady", 64'd1, 64'd0);
            end else begin
                exp_b = q_b.pop_front();
                check("B outBus", {48'd0, out_b}, {32'd0, exp_b[34:3]});
                check("B flags", {61'd0, ovf_b, unf_b, inv_b}, {61'd0, exp_b[2:0]});
            end
        end
        rr_b_prev <= rr_b;
    end

    // Present one operand; holds inReady for 'hold' extra cycles while acked.
    task automatic send(input logic [31:0] v, input int hold, output bit ok);
        ok       = 1'b0;
        in_bus   = v;
        in_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (w_acc) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("inAccepted timeout", 64'd0, 64'd1);
            in_ready = 1'b0;
            return;
        end
        for (int i = 0; i < hold; i++) begin
            in_bus = ~v;   // a second capture would corrupt the product
            @(negedge clk);
            check("inAccepted held", {63'd0, w_acc}, 64'd1);
        end
        in_ready = 1'b0;
    endtask

    // Load both operands; returns on the negedge where inReady drops in ACK_Y.
    task automatic load(input logic [31:0] x, y, input int ack_hold, output bit ok);
        bit dropped;
        send(x, ack_hold, ok);
        if (!ok) return;
        dropped = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!w_acc) begin
                dropped = 1'b1;
                break;
            end
        end
        if (!dropped) begin
            check("inAccepted release timeout", 64'd0, 64'd1);
            ok = 1'b0;
            return;
        end
        send(y, 0, ok);
    endtask

    task automatic run_op(input logic s, input logic [31:0] x, y, exp_o,
                          input logic [2:0] exp_f, input int ack_hold, acc_hold);
        bit ok, found;
        int lat;
        sel = s;
        if (s) q_b.push_back({exp_o, exp_f});
        else   q_a.push_back({exp_o, exp_f});
        load(x, y, ack_hold, ok);
        if (!ok) return;
        @(posedge clk);                     // MUL entry edge
        lat   = 0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            lat++;
            #1;
            if (w_rr) begin
                found = 1'b1;
                break;
            end
        end
        check("resultReady latency", 64'(lat), s ? 64'd13 : 64'd26);
        if (!found) return;
        @(negedge clk);
        res_acc = 1'b1;
        for (int i = 0; i < acc_hold; i++) begin
            @(negedge clk);
            check("resultReady low in DONE", {63'd0, w_rr}, 64'd0);
        end
        res_acc = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        rst      = 1'b0;
        in_ready = 1'b0;
        in_bus   = '0;
        res_acc  = 1'b0;
        sel      = 1'b0;
        repeat (3) @(negedge clk);
        check("reset A outputs", {29'd0, out_a, acc_a, rr_a, ovf_a, unf_a, inv_a}, 64'd0);
        check("reset B outputs", {45'd0, out_b, acc_b, rr_b, ovf_b, unf_b, inv_b}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Basic product with long handshakes on both sides.
        run_op(1'b0, 32'h40000000, 32'h40400000, 32'h40C00000, 3'b000, 3, 4);
        // Rounding: sticky only, ties to odd -> up, ties to even -> stay.
        run_op(1'b0, 32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000, 0, 1);
        run_op(1'b0, 32'hBFC00000, 32'h3FC00000, 32'hC0100000, 3'b000, 0, 1);
        run_op(1'b0, 32'h3FC00000, 32'h3F800001, 32'h3FC00002, 3'b000, 1, 1);
        run_op(1'b0, 32'h3F800003, 32'h3FC00000, 32'h3FC00004, 3'b000, 0, 2);
        // Specials.
        run_op(1'b0, 32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001, 0, 1);
        run_op(1'b0, 32'hFFC00001, 32'h3F800000, 32'h7FC00000, 3'b001, 0, 1);
        run_op(1'b0, 32'h7F800000, 32'hC0000000, 32'hFF800000, 3'b000, 0, 1);
        run_op(1'b0, 32'h80000000, 32'h40A00000, 32'h80000000, 3'b000, 0, 1);
        run_op(1'b0, 32'h00000001, 32'h40000000, 32'h00000000, 3'b000, 0, 1);
        // Exponent range boundaries.
        run_op(1'b0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b100, 0, 1);
        run_op(1'b0, 32'h7F000000, 32'h3F800000, 32'h7F000000, 3'b000, 0, 1);
        run_op(1'b0, 32'h00800000, 32'h00800000, 32'h00000000, 3'b010, 0, 1);
        run_op(1'b0, 32'h00800000, 32'h3F800000, 32'h00800000, 3'b000, 0, 1);
        run_op(1'b0, 32'h80800000, 32'h3F000000, 32'h80000000, 3'b010, 0, 1);
        // Nonzero outBus left behind so the abort clearly clears it.
        run_op(1'b0, 32'h40000000, 32'h40400000, 32'h40C00000, 3'b000, 0, 1);

        // Abort during the 5th MUL cycle.
        sel = 1'b0;
        load(32'h40000000, 32'h40400000, 0, ok);
        @(posedge clk);                     // MUL entry
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort clears outputs", {29'd0, out_a, acc_a, rr_a, ovf_a, unf_a, inv_a}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_op(1'b0, 32'h40000000, 32'h40400000, 32'h40C00000, 3'b000, 0, 1);

        // Half-precision-like build: 2.0 x 3.0.
        run_op(1'b1, 32'h00004000, 32'h00004200, 32'h00004600, 3'b000, 0, 1);
        sel = 1'b0;

        repeat (5) @(negedge clk);
        check("A queue drained", 64'(q_a.size()), 64'd0);
        check("B queue drained", 64'(q_b.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_mul_seq_param.md
FP_MUL_SEQ_PARAM -- requirements
Module: fp_mul_seq_param

Interface
REQ-001 Parameter EW, default 8, exponent field width (legal range 4..11).
REQ-002 Parameter MW, default 23, stored fraction width (legal range 4..52); W = 1+EW+MW; BIAS = 2^(EW-1)-1.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low.
REQ-005 inReady  input  1  producer has an operand on inBus.
REQ-006 inBus  input  W  operand word {sign, exponent, fraction}.
REQ-007 inAccepted  output  1  operand captured; producer shall drop inReady.
REQ-008 resultAccepted  input  1  consumer has taken outBus.
REQ-009 outBus  output  W  product word; valid while resultReady=1.
REQ-010 resultReady  output  1  outBus and flags valid.
REQ-011 ovf  output  1  finite result exceeded max exponent; forced to infinity.
REQ-012 unf  output  1  nonzero result below min normal; flushed to signed zero.
REQ-013 inv  output  1  invalid operation (NaN operand or inf x 0); result is canonical quiet NaN.

Function
REQ-014 Registered Moore FSM with states IDLE_X, ACK_X, IDLE_Y, ACK_Y, MUL, NORM, RDY, DONE; inAccepted and resultReady decode from state only.
REQ-015 IDLE_X: inReady=1 at an edge -> xreg<=inBus, go ACK_X; ACK_X: inAccepted=1, stay while inReady=1, else go IDLE_Y.
REQ-016 IDLE_Y / ACK_Y mirror REQ-015 into yreg; leaving ACK_Y clears the iteration counter and product register and enters MUL.
REQ-017 MUL: shift-add of the two (MW+1)-bit significands (hidden 1 prepended), one multiplier bit per cycle, exactly MW+1 cycles, producing a 2*(MW+1)-bit product.
REQ-018 NORM: one cycle; normalize (product bit 2MW+1 set -> shift right 1, exponent+1), round to nearest even using guard and sticky bits, renormalize on rounding carry, apply special cases, register outBus and flags.
REQ-019 Exponent arithmetic uses EW+2 signed bits: e = ex + ey - BIAS + norm + roundcarry; no truncation before range check.
REQ-020 Result sign = sx XOR sy for all outcomes except NaN (NaN sign 0).
REQ-021 Operand exponent 0 is treated as zero (subnormal inputs flushed, fraction ignored).
REQ-022 Priority: NaN operand or inf x 0 -> 0,all-ones exp, fraction MSB=1, inv=1; else inf operand -> signed inf; else zero operand -> signed zero; else e >= 2^EW-1 -> signed inf, ovf=1; else e <= 0 -> signed zero, unf=1; else normal.
REQ-023 Fixed latency: MUL entered on the edge after inReady drops in ACK_Y; resultReady rises exactly MW+3 edges later, independent of operand values.
REQ-024 RDY: resultReady=1, outBus and flags held stable; resultAccepted=1 -> DONE.
REQ-025 DONE: resultReady=0, outBus held; stay while resultAccepted=1, then go IDLE_X.
REQ-026 inReady is ignored in MUL, NORM, RDY, DONE; resultAccepted is ignored outside RDY and DONE.
REQ-027 xreg, yreg unchanged from capture until next capture; outBus changes only in NORM.

Reset
REQ-028 rst=0 at an edge -> state IDLE_X; xreg, yreg, product, counter, outBus, ovf, unf, inv cleared to 0; inAccepted=0, resultReady=0.
REQ-029 Reset asserted in any state, including mid-MUL, aborts the operation; no partial result is ever presented.
REQ-030 With rst=0, inputs have no effect on state.

Verification
REQ-031 Default params: x=0x40000000, y=0x40400000 -> outBus=0x40C00000, flags 0, resultReady rises 26 edges after leaving ACK_Y.
REQ-032 Rounding: x=y=0x3F800001 -> 0x3F800002; x=0xBFC00000, y=0x3FC00000 -> 0xC0100000.
REQ-033 Specials: 0x7F800000 x 0x00000000 -> 0x7FC00000, inv=1; 0x7F000000 x 0x7F000000 -> 0x7F800000, ovf=1; 0x00800000 x 0x00800000 -> 0x00000000, unf=1.
REQ-034 EW=5, MW=10: 0x4000 x 0x4200 -> 0x4600, resultReady 13 edges after MUL entry.
REQ-035 Handshake: hold inReady high 3 cycles in ACK_X -> single capture, inAccepted held; hold resultAccepted 4 cycles -> resultReady low from DONE entry, no new capture until IDLE_X.
REQ-036 Assert rst=0 on 5th MUL cycle -> all outputs 0 next edge; following full operation 2.0 x 3.0 yields 0x40C00000.
